// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types for the SRAM bus controller: address/data words and FSM states.
package sram_bus_ctrl_pkg;

    typedef logic [19:0] Ram_addr_t;
    typedef logic [31:0] Word_t;
    typedef logic        Bit_t;

    // Wait-state counter width; WAIT_STATES is limited to 0..7.
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_LATCH,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sram_bus_ctrl.sv
// Bus-to-asynchronous-SRAM bridge. One transfer at a time: the request is
// captured on leaving IDLE, the strobe sequence runs off the FSM, and the
// bus sees a single stall-low cycle (DONE) when the transfer is complete.
module sram_bus_ctrl
    import sram_bus_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  Ram_addr_t   bus_addr,
    input  Bit_t        read_op,
    input  Bit_t        write_op,
    input  Word_t       bus_data_write,
    input  logic [3:0]  bus_byte_en,
    output Word_t       bus_data_read,
    output Bit_t        bus_stall,
    output Ram_addr_t   sram_addr,
    inout  wire  [31:0] sram_data,
    output Bit_t        sram_ce_n,
    output Bit_t        sram_oe_n,
    output Bit_t        sram_we_n,
    output logic [3:0]  sram_be_n
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    Ram_addr_t        addr_q;
    Word_t            wdata_q;
    logic [3:0]       be_q;
    Word_t            rdata_q;

    logic             capture;
    logic             latch;
    logic             drive;

    // Next-state, counter and strobe decode; strobes come straight from the state register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        latch     = 1'b0;
        drive     = 1'b0;
        bus_stall = 1'b1;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_be_n = 4'hF;
        case (state_q)
            IDLE: begin
                // Stall is combinational here so the master sees it in the request cycle.
                bus_stall = read_op | write_op;
                if (write_op) begin
                    capture = 1'b1;
                    state_d = WR_SETUP;
                end else if (read_op) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RD_LATCH;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            RD_WAIT: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'h0;
                if (cnt_q == '0) state_d = RD_LATCH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RD_LATCH: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'h0;
                latch     = 1'b1;
                state_d   = DONE;
            end
            WR_SETUP: begin
                sram_ce_n = 1'b0;
                sram_be_n = ~be_q;
                drive     = 1'b1;
                cnt_d     = CNT_W'(WAIT_STATES);
                state_d   = WR_PULSE;
            end
            WR_PULSE: begin
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
                sram_be_n = ~be_q;
                drive     = 1'b1;
                if (cnt_q == '0) state_d = WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WR_HOLD: begin
                // Data held one cycle past the rising edge of we_n.
                sram_ce_n = 1'b0;
                sram_be_n = ~be_q;
                drive     = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                bus_stall = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and counter; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on acceptance; bus changes after that are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (capture) begin
            addr_q  <= bus_addr;
            wdata_q <= bus_data_write;
            be_q    <= bus_byte_en;
        end
    end

    // Read data register; holds the last read word through writes and idle.
    always_ff @(posedge clk) begin
        if (!rst)       rdata_q <= '0;
        else if (latch) rdata_q <= sram_data;
    end

    assign sram_addr     = addr_q;
    assign bus_data_read = rdata_q;
    assign sram_data     = drive ? wdata_q : {32{1'bz}};

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: two instances (WAIT_STATES 1 and 0), each with
// an SRAM model; a reference memory feeds a scoreboard of expected results.
module tb_sram_bus_ctrl;

    typedef struct {
        int          dev;
        bit          wr;
        int          lat;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] addr  [2];
    logic        rd_op [2];
    logic        wr_op [2];
    logic [31:0] wdat  [2];
    logic [3:0]  ben   [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic [19:0] saddr [2];
    logic        ce_n  [2];
    logic        oe_n  [2];
    logic        we_n  [2];
    logic [3:0]  be_n  [2];

    logic [31:0] ref_mem [2][0:255];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ovl   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA5A5_0000 ^ 32'(i * 257));
    endfunction

    function automatic int ws_of(int d);
        return (d == 0) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire  [31:0] sd;
        logic [31:0] mem [0:255];

        sram_bus_ctrl #(.WAIT_STATES(g == 0 ? 1 : 0)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .bus_addr       (addr[g]),
            .read_op        (rd_op[g]),
            .write_op       (wr_op[g]),
            .bus_data_write (wdat[g]),
            .bus_byte_en    (ben[g]),
            .bus_data_read  (rdata[g]),
            .bus_stall      (stall[g]),
            .sram_addr      (saddr[g]),
            .sram_data      (sd),
            .sram_ce_n      (ce_n[g]),
            .sram_oe_n      (oe_n[g]),
            .sram_we_n      (we_n[g]),
            .sram_be_n      (be_n[g])
        );

        assign sd = (!ce_n[g] && !oe_n[g]) ? mem[saddr[g][7:0]] : {32{1'bz}};

        initial begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end

        always @(posedge clk) begin
            if (!ce_n[g] && !we_n[g])
                for (int b = 0; b < 4; b++)
                    if (!be_n[g][b]) mem[saddr[g][7:0]][8*b +: 8] <= sd[8*b +: 8];
        end
    end

    // Read and write strobes must never be low together on either instance.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            if (!oe_n[i] && !we_n[i]) ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic xfer(input int d, input bit wr, input bit both, input logic [19:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input bit drop);
        exp_t e;
        int   k = 0;
        int   oe_c = 0;
        int   we_c = 0;
        bit   done = 0;
        e.dev = d;
        e.wr  = wr | both;
        e.lat = e.wr ? ws_of(d) + 4 : ws_of(d) + 2;
        if (e.wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[d][a[7:0]][8*b +: 8] = wd[8*b +: 8];
        e.data = ref_mem[d][a[7:0]];
        sb.push_back(e);
        addr[d]  = a;
        wdat[d]  = wd;
        ben[d]   = be;
        wr_op[d] = wr | both;
        rd_op[d] = !wr | both;
        while (!done && k < 40) begin
            @(negedge clk);
            if (!oe_n[d]) oe_c++;
            if (!we_n[d]) we_c++;
            if (k == 1) chk("addr", 32'(saddr[d]), 32'(a));
            if (!stall[d]) done = 1;
            else begin
                if (k == 1) begin
                    addr[d] = 20'($urandom);
                    wdat[d] = $urandom;
                    ben[d]  = 4'($urandom);
                    if (drop) begin
                        rd_op[d] = 1'b0;
                        wr_op[d] = 1'b0;
                    end
                end
                k++;
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        e = sb.pop_front();
        chk("latency", 32'(k), 32'(e.lat));
        if (!e.wr) chk("rdata", rdata[e.dev], e.data);
        chk("oe_cycles", 32'(oe_c), e.wr ? 32'd0 : 32'(ws_of(d) + 1));
        chk("we_cycles", 32'(we_c), e.wr ? 32'(ws_of(d) + 1) : 32'd0);
        @(posedge clk);
        #1;
        rd_op[d] = 1'b0;
        wr_op[d] = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; rd_op[d] = 0; wr_op[d] = 0; wdat[d] = '0; ben[d] = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ce", 32'(ce_n[d]), 32'd1);
            chk("rst_oe", 32'(oe_n[d]), 32'd1);
            chk("rst_we", 32'(we_n[d]), 32'd1);
            chk("rst_be", 32'(be_n[d]), 32'hF);
            chk("rst_stall", 32'(stall[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_addr", 32'(saddr[d]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;

        // WAIT_STATES=1 directed cases
        xfer(0, 0, 0, 20'd5, 32'h0, 4'h0, 0);
        xfer(0, 1, 0, 20'd9, 32'h12345678, 4'hF, 0);
        chk("mem9_full", g_dut[0].mem[9], 32'h12345678);
        xfer(0, 1, 0, 20'd9, 32'hAABBCCDD, 4'b0011, 1);
        chk("mem9_part", g_dut[0].mem[9], 32'h1234CCDD);
        xfer(0, 0, 1, 20'd3, 32'h0BADF00D, 4'hF, 0);
        chk("mem3_both", g_dut[0].mem[3], 32'h0BADF00D);
        xfer(0, 0, 0, 20'd9, 32'h0, 4'h0, 1);

        // WAIT_STATES=0 back-to-back, then mixed random traffic
        xfer(1, 0, 0, 20'd0, 32'h0, 4'h0, 0);
        xfer(1, 1, 0, 20'd1, 32'hCAFEF00D, 4'hF, 0);
        xfer(1, 0, 0, 20'd1, 32'h0, 4'h0, 0);
        for (int i = 0; i < 8; i++)
            xfer(1, bit'($urandom_range(0, 1)), 0, 20'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(1, 15)), bit'($urandom_range(0, 1)));

        // Reset in the middle of a write pulse
        addr[0] = 20'd50; wdat[0] = 32'h55AA55AA; ben[0] = 4'hF; wr_op[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (!we_n[0]) seen = 1;
        end
        chk("we_seen", 32'(seen), 32'd1);
        rst = 1'b0;
        wr_op[0] = 1'b0;
        @(negedge clk);
        chk("mid_we", 32'(we_n[0]), 32'd1);
        chk("mid_ce", 32'(ce_n[0]), 32'd1);
        chk("mid_be", 32'(be_n[0]), 32'hF);
        chk("mid_stall", 32'(stall[0]), 32'd0);
        chk("mid_addr", 32'(saddr[0]), 32'd0);
        chk("mid_rdata", rdata[0], 32'd0);
        rd_op[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_oe", 32'(oe_n[0]), 32'd1);
            chk("rst_hold_ce", 32'(ce_n[0]), 32'd1);
        end
        rd_op[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        xfer(0, 0, 0, 20'd9, 32'h0, 4'h0, 0);

        chk("overlap", 32'(ovl), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bus_ctrl.md
SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 Parameter: WAIT_STATES, 1, extra access cycles per transfer (legal 0..7).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 bus_addr  in  20 (Ram_addr_t)  word address from bus master.
REQ-005 read_op  in  1  read request, held until bus_stall low.
REQ-006 write_op  in  1  write request, held until bus_stall low.
REQ-007 bus_data_write  in  32 (Word_t)  write data.
REQ-008 bus_byte_en  in  4  active-high byte enables for writes (reads use all bytes).
REQ-009 bus_data_read  out  32 (Word_t)  read data, valid in the cycle bus_stall is low after a read.
REQ-010 bus_stall  out  1  high while an accepted request is not complete.
REQ-011 sram_addr  out  20  SRAM address pins.
REQ-012 sram_data  inout  32  SRAM data pins, tristated unless writing.
REQ-013 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-014 sram_be_n  out  4  active-low byte lanes.

Function
REQ-015 FSM states: IDLE, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-016 IDLE: write_op -> WR_SETUP; else read_op -> RD_WAIT; both high -> write wins; neither -> stay.
REQ-017 Address, byte enables and write data captured into registers on the IDLE->active edge; later bus changes ignored until DONE.
REQ-018 RD_WAIT: ce_n=0, oe_n=0, be_n=0; held WAIT_STATES cycles via down-counter, then RD_LATCH.
REQ-019 RD_LATCH: sram_data sampled into read register at end of cycle; next DONE.
REQ-020 WR_SETUP: one cycle, ce_n=0, we_n=1, data driven; next WR_PULSE.
REQ-021 WR_PULSE: we_n=0 for WAIT_STATES+1 cycles, be_n=~byte_en; next WR_HOLD.
REQ-022 WR_HOLD: one cycle, we_n=1, ce_n=0, data still driven; next DONE.
REQ-023 sram_data driven only in WR_SETUP, WR_PULSE, WR_HOLD; high-Z otherwise.
REQ-024 oe_n and we_n never low in the same cycle.
REQ-025 DONE: strobes inactive, bus_stall=0, bus_data_read holds latched word; next IDLE.
REQ-026 bus_stall = (read_op|write_op) in IDLE, 1 in all states except DONE and IDLE, 0 in DONE (combinational in IDLE, registered otherwise).
REQ-027 Read latency: request seen at cycle 0 -> stall low at cycle WAIT_STATES+2; write: cycle WAIT_STATES+4.
REQ-028 Request dropped mid-transfer: transfer still completes; no abort.
REQ-029 WAIT_STATES=0: RD_WAIT skipped (IDLE->RD_LATCH with strobes asserted), WR_PULSE one cycle.
REQ-030 bus_data_read keeps last read value through writes and idle.

Reset
REQ-031 rst low at an edge: state IDLE, counter 0, ce_n/oe_n/we_n=1, be_n=4'hF, sram_data high-Z, bus_data_read=0, sram_addr=0, regardless of in-flight transfer.
REQ-032 Transfer interrupted by reset is lost; no request accepted while rst low.

Structure
REQ-033 Ram_addr_t, Word_t, Bit_t and the FSM state enum live in the shared defines package.
REQ-034 Single module; no sub-modules; tristate via continuous assign on sram_data.

Verification
REQ-035 Read addr 5 (mem=32'hDEADBEEF), WAIT_STATES=1 -> stall low cycle 3, bus_data_read=32'hDEADBEEF, oe_n low cycles 1-2.
REQ-036 Write addr 9, data 32'h12345678, byte_en 4'hF -> mem[9]=32'h12345678, stall low cycle 5, we_n low exactly 2 cycles.
REQ-037 Write addr 9 data 32'hAABBCCDD byte_en 4'b0011 over 32'h12345678 -> mem[9]=32'h1234CCDD.
REQ-038 read_op and write_op both high, addr 3 -> write performed, no oe_n pulse.
REQ-039 rst low during WR_PULSE -> next edge we_n=1, sram_data high-Z, state IDLE, bus_stall=0.
REQ-040 Back-to-back read 0, write 1, read 1 with WAIT_STATES=0 -> read 1 returns written word, no strobe overlap.
